// File: rtl/pal_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : pal_rr_scheduler
// Purpose  : Round-robin sharing of one fixed-latency datapath among N_REQ
//            requesters, with owner tracking and result routing.
// Revision : 1.0
// ============================================================================
module pal_rr_scheduler #(
    parameter int N_REQ   = 4,
    parameter int W_DATA  = 32,
    parameter int DP_LAT  = 3,
    parameter int MAX_OUT = 4
) (
    input  logic                    i_clk,
    input  logic                    resetn,
    input  logic                    i_en,
    input  logic                    i_flush,
    input  logic [N_REQ-1:0]        i_req_valid,
    output logic [N_REQ-1:0]        o_req_ready,
    input  logic [N_REQ*W_DATA-1:0] i_req_a,
    input  logic [N_REQ*W_DATA-1:0] i_req_b,
    output logic                    o_dp_valid,
    output logic [W_DATA-1:0]       o_dp_a,
    output logic [W_DATA-1:0]       o_dp_b,
    input  logic                    i_dp_valid,
    input  logic [W_DATA-1:0]       i_dp_result,
    output logic [N_REQ-1:0]        o_rsp_valid,
    output logic [W_DATA-1:0]       o_rsp_data,
    output logic                    o_busy,
    output logic [1:0]              o_state,
    output logic                    o_err
);
    localparam int c_PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int c_JW = c_PW + 1;
    localparam int c_CW = $clog2(MAX_OUT + 1);
    localparam int c_TP = DP_LAT + 1;
    localparam logic [c_JW-1:0] c_NREQ_J = c_JW'(N_REQ);
    localparam logic [c_PW-1:0] c_LAST   = c_PW'(N_REQ - 1);
    localparam logic [c_CW-1:0] c_MAX    = c_CW'(MAX_OUT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [c_PW-1:0]           r_ptr;
    logic [c_CW-1:0]           r_cnt;
    logic [c_TP-1:0]           r_tag_v;
    logic [c_TP-1:0][c_PW-1:0] r_tag_idx;
    logic                      r_dp_valid;
    logic [W_DATA-1:0]         r_dp_a;
    logic [W_DATA-1:0]         r_dp_b;
    logic [N_REQ-1:0]          r_rsp_valid;
    logic [W_DATA-1:0]         r_rsp_data;
    logic                      r_err;

    logic [W_DATA-1:0]         w_a_arr [N_REQ];
    logic [W_DATA-1:0]         w_b_arr [N_REQ];
    logic                      w_found;
    logic [c_PW-1:0]           w_win;
    logic [c_JW-1:0]           w_j;
    logic                      w_grant_ok;
    logic                      w_hs;
    logic                      w_head_v;
    logic [c_PW-1:0]           w_head_idx;
    logic                      w_rsp_take;
    logic [N_REQ-1:0]          w_ready;
    logic [N_REQ-1:0]          w_rsp_oh;

    for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
        assign w_a_arr[k] = i_req_a[k*W_DATA +: W_DATA];
        assign w_b_arr[k] = i_req_b[k*W_DATA +: W_DATA];
    end

    // First valid requester at or above the pointer, wrapping modulo N_REQ.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_j     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_j = {1'b0, r_ptr} + c_JW'(i);
            if (w_j >= c_NREQ_J) begin
                w_j = w_j - c_NREQ_J;
            end
            if (!w_found && i_req_valid[w_j[c_PW-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_j[c_PW-1:0];
            end
        end
    end

    assign w_grant_ok = (r_state == S_RUN) && (r_cnt < c_MAX);
    assign w_hs       = w_grant_ok && w_found;
    assign w_head_v   = r_tag_v[c_TP-1];
    assign w_head_idx = r_tag_idx[c_TP-1];
    assign w_rsp_take = i_dp_valid && w_head_v;

    always_comb begin
        w_ready  = '0;
        w_rsp_oh = '0;
        if (w_hs) begin
            w_ready[w_win] = 1'b1;
        end
        w_rsp_oh[w_head_idx] = 1'b1;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_en && !i_flush) w_state_nxt = S_RUN;
            S_RUN:   if (!i_en || i_flush) w_state_nxt = S_DRAIN;
            S_DRAIN: if (!i_flush && (r_cnt == '0) && (r_tag_v == '0)) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_cnt       <= '0;
            r_tag_v     <= '0;
            r_tag_idx   <= '0;
            r_dp_valid  <= 1'b0;
            r_dp_a      <= '0;
            r_dp_b      <= '0;
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_hs) begin
                r_ptr  <= (w_win == c_LAST) ? '0 : w_win + 1'b1;
                r_dp_a <= w_a_arr[w_win];
                r_dp_b <= w_b_arr[w_win];
            end
            // The head entry retires whether or not its result actually arrived.
            case ({w_hs, w_head_v})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
            r_tag_v     <= {r_tag_v[c_TP-2:0], w_hs};
            r_tag_idx   <= {r_tag_idx[c_TP-2:0], w_win};
            r_dp_valid  <= w_hs;
            r_rsp_valid <= w_rsp_take ? w_rsp_oh : '0;
            if (w_rsp_take) begin
                r_rsp_data <= i_dp_result;
            end
            if (i_dp_valid != w_head_v) begin
                r_err <= 1'b1;
            end
        end
    end

    assign o_req_ready = w_ready;
    assign o_dp_valid  = r_dp_valid;
    assign o_dp_a      = r_dp_a;
    assign o_dp_b      = r_dp_b;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_data  = r_rsp_data;
    assign o_busy      = (r_state != S_IDLE) || (r_cnt != '0);
    assign o_state     = r_state;
    assign o_err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_pal_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_pal_rr_scheduler
// Purpose  : Directed bench with an adder datapath model and response scoreboard.
// Revision : 1.0
// ============================================================================
module tb_pal_rr_scheduler;
    localparam int c_N   = 4;
    localparam int c_W   = 32;
    localparam int c_LAT = 3;
    localparam int c_MO  = 4;

    logic               i_clk = 1'b0;
    logic               resetn;
    logic               i_en;
    logic               i_flush;
    logic [c_N-1:0]     i_req_valid;
    logic [c_N-1:0]     o_req_ready;
    logic [c_N*c_W-1:0] i_req_a;
    logic [c_N*c_W-1:0] i_req_b;
    logic               o_dp_valid;
    logic [c_W-1:0]     o_dp_a;
    logic [c_W-1:0]     o_dp_b;
    logic               i_dp_valid;
    logic [c_W-1:0]     i_dp_result;
    logic [c_N-1:0]     o_rsp_valid;
    logic [c_W-1:0]     o_rsp_data;
    logic               o_busy;
    logic [1:0]         o_state;
    logic               o_err;

    pal_rr_scheduler #(
        .N_REQ(c_N), .W_DATA(c_W), .DP_LAT(c_LAT), .MAX_OUT(c_MO)
    ) u_dut (
        .i_clk(i_clk), .resetn(resetn), .i_en(i_en), .i_flush(i_flush),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_a(i_req_a), .i_req_b(i_req_b),
        .o_dp_valid(o_dp_valid), .o_dp_a(o_dp_a), .o_dp_b(o_dp_b),
        .i_dp_valid(i_dp_valid), .i_dp_result(i_dp_result),
        .o_rsp_valid(o_rsp_valid), .o_rsp_data(o_rsp_data),
        .o_busy(o_busy), .o_state(o_state), .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;

    // Adder datapath model; r_late adds one extra cycle of latency.
    logic [c_LAT:0] r_dpv = '0;
    logic [c_W-1:0] r_dpr [0:c_LAT];
    logic           r_late = 1'b0;
    always @(posedge i_clk) begin
        r_dpv    <= {r_dpv[c_LAT-1:0], o_dp_valid};
        r_dpr[0] <= o_dp_a + o_dp_b;
        for (int k = 1; k <= c_LAT; k++) r_dpr[k] <= r_dpr[k-1];
    end
    assign i_dp_valid  = r_late ? r_dpv[c_LAT] : r_dpv[c_LAT-1];
    assign i_dp_result = r_late ? r_dpr[c_LAT] : r_dpr[c_LAT-1];

    typedef struct {
        int          owner;
        logic [31:0] data;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    int n_checks  = 0;
    int n_errors  = 0;
    int cyc       = 0;
    int rsp_count = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge i_clk) cyc++;

    // Monitor: issue stage, response scoreboard and ready sanity.
    logic        prev_hs = 1'b0;
    logic [31:0] prev_a, prev_b;
    always @(negedge i_clk) begin
        if (!resetn) begin
            prev_hs = 1'b0;
        end else begin
            logic [c_N-1:0] hs;
            exp_t e;
            check("ready_onehot0", 64'($onehot0(o_req_ready)), 64'd1);
            check("dp_valid", 64'(o_dp_valid), 64'(prev_hs));
            if (prev_hs) begin
                check("dp_a", 64'(o_dp_a), 64'(prev_a));
                check("dp_b", 64'(o_dp_b), 64'(prev_b));
            end
            if (o_rsp_valid !== '0) begin
                if (sb.size() == 0) begin
                    check("rsp_unexpected", 64'(o_rsp_valid), 64'd0);
                end else begin
                    e = sb.pop_front();
                    rsp_count++;
                    check("rsp_owner", 64'(o_rsp_valid), 64'(1 << e.owner));
                    check("rsp_data", 64'(o_rsp_data), 64'(e.data));
                    check("rsp_latency", 64'(cyc), 64'(e.cyc + c_LAT + 2));
                end
            end
            hs      = o_req_ready & i_req_valid;
            prev_hs = |hs;
            for (int k = c_N - 1; k >= 0; k--) begin
                if (hs[k]) begin
                    prev_a = i_req_a[k*c_W +: c_W];
                    prev_b = i_req_b[k*c_W +: c_W];
                    e.owner = k;
                    e.data  = prev_a + prev_b;
                    e.cyc   = cyc;
                end
            end
            if (prev_hs) sb.push_back(e);
        end
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic [31:0] a, input logic [31:0] b);
        i_req_a[k*c_W +: c_W] = a;
        i_req_b[k*c_W +: c_W] = b;
    endtask

    task automatic do_reset();
        i_en        = 1'b0;
        i_flush     = 1'b0;
        i_req_valid = '0;
        resetn      = 1'b0;
        step();
        step();
        sb.delete();
        resetn = 1'b1;
    endtask

    task automatic wait_sb_empty(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            step();
            n++;
        end
        check(tag, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited;
        int g;
        int base;
        logic [c_N-1:0] exp_rdy;
        i_req_a = '0;
        i_req_b = '0;
        do_reset();
        resetn = 1'b0;
        step();
        #1;
        check("rst_state", 64'(o_state), 64'd0);
        check("rst_busy", 64'(o_busy), 64'd0);
        check("rst_ready", 64'(o_req_ready), 64'd0);
        check("rst_rsp", 64'(o_rsp_valid), 64'd0);
        check("rst_err", 64'(o_err), 64'd0);
        check("rst_dpv", 64'(o_dp_valid), 64'd0);
        resetn = 1'b1;

        // Single request from requester 0.
        i_en = 1'b1;
        step();
        check("t1_state_run", 64'(o_state), 64'd1);
        check("t1_busy", 64'(o_busy), 64'd1);
        set_req(0, 32'd3, 32'd4);
        i_req_valid = 4'b0001;
        #1;
        check("t1_ready", 64'(o_req_ready), 64'b0001);
        step();
        i_req_valid = '0;
        check("t1_dp_valid", 64'(o_dp_valid), 64'd1);
        check("t1_dp_a", 64'(o_dp_a), 64'd3);
        waited = 0;
        while (o_rsp_valid === '0 && waited < 20) begin
            step();
            waited++;
        end
        check("t1_rsp_wait", 64'(waited), 64'(c_LAT + 1));
        check("t1_rsp_valid", 64'(o_rsp_valid), 64'b0001);
        check("t1_rsp_data", 64'(o_rsp_data), 64'd7);

        // All requesters continuously valid; the MAX_OUT cap forces a gap every 5th cycle.
        do_reset();
        i_en = 1'b1;
        step();
        for (int k = 0; k < c_N; k++) set_req(k, 32'(100 + k), 32'(7 * k));
        i_req_valid = 4'b1111;
        g = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            exp_rdy = '0;
            if (c % 5 != 4) begin
                exp_rdy[g % c_N] = 1'b1;
                g++;
            end
            check("t2_ready", 64'(o_req_ready), 64'(exp_rdy));
            step();
        end
        i_req_valid = '0;
        wait_sb_empty("t2_drain");
        check("t2_err", 64'(o_err), 64'd0);

        // Flush with three ops in flight.
        base = rsp_count;
        i_req_valid = 4'b0111;
        step();
        step();
        step();
        i_req_valid = '0;
        i_flush = 1'b1;
        step();
        check("t4_state_drain", 64'(o_state), 64'd2);
        i_req_valid = 4'b1111;
        waited = 0;
        while (sb.size() != 0 && waited < 40) begin
            #1;
            check("t4_no_grant", 64'(o_req_ready), 64'd0);
            check("t4_busy", 64'(o_busy), 64'd1);
            step();
            waited++;
        end
        check("t4_all_rsp", 64'(rsp_count - base), 64'd3);
        step();
        check("t4_flush_holds", 64'(o_state), 64'd2);
        i_flush = 1'b0;
        i_en = 1'b0;
        i_req_valid = '0;
        step();
        check("t4_idle", 64'(o_state), 64'd0);
        check("t4_busy_low", 64'(o_busy), 64'd0);

        // Datapath returns its result one cycle late.
        i_en = 1'b1;
        step();
        r_late = 1'b1;
        set_req(3, 32'd20, 32'd22);
        i_req_valid = 4'b1000;
        step();
        i_req_valid = '0;
        check("t5_err_before", 64'(o_err), 64'd0);
        for (int c = 0; c < c_LAT + 4; c++) step();
        check("t5_err_set", 64'(o_err), 64'd1);
        check("t5_no_rsp", 64'(sb.size()), 64'd1);
        sb.delete();
        r_late = 1'b0;
        i_en = 1'b0;
        for (int c = 0; c < 4; c++) step();
        check("t5_err_sticky", 64'(o_err), 64'd1);

        // Asynchronous reset with two ops in flight.
        do_reset();
        check("t6_err_cleared", 64'(o_err), 64'd0);
        i_en = 1'b1;
        step();
        set_req(0, 32'd1, 32'd2);
        set_req(1, 32'd5, 32'd6);
        i_req_valid = 4'b0011;
        step();
        step();
        i_req_valid = '0;
        i_en = 1'b0;
        #1;
        resetn = 1'b0;
        #1;
        check("t6_state", 64'(o_state), 64'd0);
        check("t6_busy", 64'(o_busy), 64'd0);
        check("t6_dpv", 64'(o_dp_valid), 64'd0);
        check("t6_dp_a", 64'(o_dp_a), 64'd0);
        check("t6_rsp", 64'(o_rsp_valid), 64'd0);
        check("t6_rsp_data", 64'(o_rsp_data), 64'd0);
        sb.delete();
        base = rsp_count;
        step();
        resetn = 1'b1;
        for (int c = 0; c < c_LAT + 3; c++) step();
        check("t6_err_orphan", 64'(o_err), 64'd1);
        check("t6_no_rsp", 64'(rsp_count - base), 64'd0);
        check("t6_idle_busy", 64'(o_busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
